// File: rtl/bus_initiator_if.sv
// ---------------------------------------------------------------------------
// bus_initiator_if
//   Groups the pipeline request/response handshake and the single-cycle
//   word bus of the load/store initiator.
//
//   Request  : req_valid_in, req_ready_out, req_write_in, req_width_in,
//              req_unsigned_in, req_address_in, req_value_in
//   Response : resp_valid_out, resp_value_out, resp_fault_out
//   Bus      : address_out, read_out, write_mask_out, write_value_out,
//              read_value_in, ready_in
//
//   Modports
//     master : the initiator (drives the bus, answers the pipeline)
//     slave  : the environment (pipeline + responder)
// ---------------------------------------------------------------------------
interface bus_initiator_if;
   // pipeline request
   logic        req_valid_in;
   logic        req_ready_out;
   logic        req_write_in;
   logic [1:0]  req_width_in;
   logic        req_unsigned_in;
   logic [31:0] req_address_in;
   logic [31:0] req_value_in;
   // pipeline response
   logic        resp_valid_out;
   logic [31:0] resp_value_out;
   logic        resp_fault_out;
   // responder bus
   logic [31:0] address_out;
   logic        read_out;
   logic [3:0]  write_mask_out;
   logic [31:0] write_value_out;
   logic [31:0] read_value_in;
   logic        ready_in;

   modport master (
      input  req_valid_in, req_write_in, req_width_in, req_unsigned_in,
             req_address_in, req_value_in, read_value_in, ready_in,
      output req_ready_out, resp_valid_out, resp_value_out, resp_fault_out,
             address_out, read_out, write_mask_out, write_value_out
   );

   modport slave (
      output req_valid_in, req_write_in, req_width_in, req_unsigned_in,
             req_address_in, req_value_in, read_value_in, ready_in,
      input  req_ready_out, resp_valid_out, resp_value_out, resp_fault_out,
             address_out, read_out, write_mask_out, write_value_out
   );
endinterface

// File: rtl/bus_initiator.sv
// ---------------------------------------------------------------------------
// bus_initiator
//   Load/store front end of the CPU data path. Accepts one byte, halfword or
//   word access from the pipeline, issues it as one or two word-aligned bus
//   beats (misaligned accesses that cross a word are split), merges and
//   extends the read data and returns a single response pulse. Responders
//   stretch a beat by holding ready_in low; an optional per-beat timeout
//   aborts the access with a fault.
//
//   Parameters
//     TIMEOUT_CYCLES : wait cycles allowed per beat before abort (0 = never)
//
//   Ports
//     clk    : clock, all state changes on the rising edge
//     reset  : synchronous active-high reset
//     bus    : bus_initiator_if.master (request, response and bus signals)
// ---------------------------------------------------------------------------
module bus_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   bus_initiator_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   // Abort happens on the edge that ends the TIMEOUT_CYCLES-th wait cycle,
   // i.e. when the counter (cleared at beat start) already shows N-1 waits.
   localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   state_t      state_q, state_d;

   // latched request
   logic        write_q, write_d;
   logic [1:0]  width_q, width_d;
   logic        unsigned_q, unsigned_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] word_addr_q, word_addr_d;
   logic [3:0]  hi_mask_q, hi_mask_d;      // lanes of the second beat
   logic [31:0] hi_data_q, hi_data_d;      // store data of the second beat

   // captured read data
   logic [31:0] beat0_data_q, beat0_data_d;
   logic [31:0] beat1_data_q, beat1_data_d;

   logic [15:0] timer_q, timer_d;

   // registered outputs
   logic [31:0] address_q, address_d;
   logic        read_q, read_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] wvalue_q, wvalue_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_value_q, resp_value_d;
   logic        resp_fault_q, resp_fault_d;

   // ------------------------------------------------------------------
   // Lane computation for an incoming request
   // ------------------------------------------------------------------
   logic [1:0]  req_off;
   logic [3:0]  req_base;
   logic [7:0]  req_m8;
   logic [63:0] req_d64;

   always_comb begin
      req_off = bus.req_address_in[1:0];
      case (bus.req_width_in)
         2'b00:   req_base = 4'b0001;
         2'b01:   req_base = 4'b0011;
         default: req_base = 4'b1111;
      endcase
      req_m8  = {4'b0000, req_base} << req_off;
      req_d64 = {32'h0, bus.req_value_in} << {req_off, 3'b000};
   end

   // ------------------------------------------------------------------
   // Load result. The response is registered on the edge that completes
   // the last beat, so the beat finishing in this cycle contributes the
   // live bus data rather than its (not yet written) capture register.
   // ------------------------------------------------------------------
   logic [31:0] rd0, rd1;
   logic [63:0] r64;
   logic [31:0] load_ext;

   always_comb begin
      rd0 = (state_q == BEAT0) ? bus.read_value_in : beat0_data_q;
      rd1 = (state_q == BEAT1) ? bus.read_value_in : beat1_data_q;
      r64 = {rd1, rd0} >> {off_q, 3'b000};
      case (width_q)
         2'b00:   load_ext = unsigned_q ? {24'h0, r64[7:0]}
                                        : {{24{r64[7]}}, r64[7:0]};
         2'b01:   load_ext = unsigned_q ? {16'h0, r64[15:0]}
                                        : {{16{r64[15]}}, r64[15:0]};
         default: load_ext = r64[31:0];
      endcase
   end

   // ------------------------------------------------------------------
   // Beat status
   // ------------------------------------------------------------------
   logic beat_active, beat_done, beat_timeout, need_split;

   always_comb begin
      beat_active  = (state_q == BEAT0) || (state_q == BEAT1);
      beat_done    = beat_active && bus.ready_in;
      beat_timeout = TIMEOUT_EN && beat_active && !bus.ready_in
                     && (timer_q == TIMEOUT_LAST);
      need_split   = (hi_mask_q != 4'b0000);
   end

   // ------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      width_d      = width_q;
      unsigned_d   = unsigned_q;
      off_d        = off_q;
      word_addr_d  = word_addr_q;
      hi_mask_d    = hi_mask_q;
      hi_data_d    = hi_data_q;
      beat0_data_d = beat0_data_q;
      beat1_data_d = beat1_data_q;
      timer_d      = timer_q;
      address_d    = address_q;
      read_d       = read_q;
      wmask_d      = wmask_q;
      wvalue_d     = wvalue_q;
      resp_valid_d = 1'b0;
      resp_value_d = resp_value_q;
      resp_fault_d = resp_fault_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid_in) begin
               write_d      = bus.req_write_in;
               width_d      = bus.req_width_in;
               unsigned_d   = bus.req_unsigned_in;
               off_d        = req_off;
               word_addr_d  = bus.req_address_in[31:2];
               hi_mask_d    = req_m8[7:4];
               hi_data_d    = req_d64[63:32];
               beat1_data_d = 32'h0;
               timer_d      = 16'd0;
               // first beat strobes go out on this edge
               address_d    = {bus.req_address_in[31:2], 2'b00};
               read_d       = !bus.req_write_in;
               wmask_d      = bus.req_write_in ? req_m8[3:0] : 4'b0000;
               wvalue_d     = req_d64[31:0];
               state_d      = BEAT0;
            end
         end

         BEAT0, BEAT1: begin
            if (beat_done) begin
               if (state_q == BEAT0) begin
                  beat0_data_d = bus.read_value_in;
               end else begin
                  beat1_data_d = bus.read_value_in;
               end
               if ((state_q == BEAT0) && need_split) begin
                  // word address wraps naturally at 30 bits
                  address_d = {word_addr_q + 30'd1, 2'b00};
                  read_d    = !write_q;
                  wmask_d   = write_q ? hi_mask_q : 4'b0000;
                  wvalue_d  = hi_data_q;
                  timer_d   = 16'd0;
                  state_d   = BEAT1;
               end else begin
                  read_d       = 1'b0;
                  wmask_d      = 4'b0000;
                  resp_valid_d = 1'b1;
                  resp_value_d = write_q ? 32'h0 : load_ext;
                  resp_fault_d = 1'b0;
                  state_d      = RESP;
               end
            end else if (beat_timeout) begin
               read_d       = 1'b0;
               wmask_d      = 4'b0000;
               resp_valid_d = 1'b1;
               resp_value_d = 32'h0;
               resp_fault_d = 1'b1;
               state_d      = RESP;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         width_q      <= 2'b00;
         unsigned_q   <= 1'b0;
         off_q        <= 2'b00;
         word_addr_q  <= 30'h0;
         hi_mask_q    <= 4'b0000;
         hi_data_q    <= 32'h0;
         beat0_data_q <= 32'h0;
         beat1_data_q <= 32'h0;
         timer_q      <= 16'd0;
         address_q    <= 32'h0;
         read_q       <= 1'b0;
         wmask_q      <= 4'b0000;
         wvalue_q     <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_value_q <= 32'h0;
         resp_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         width_q      <= width_d;
         unsigned_q   <= unsigned_d;
         off_q        <= off_d;
         word_addr_q  <= word_addr_d;
         hi_mask_q    <= hi_mask_d;
         hi_data_q    <= hi_data_d;
         beat0_data_q <= beat0_data_d;
         beat1_data_q <= beat1_data_d;
         timer_q      <= timer_d;
         address_q    <= address_d;
         read_q       <= read_d;
         wmask_q      <= wmask_d;
         wvalue_q     <= wvalue_d;
         resp_valid_q <= resp_valid_d;
         resp_value_q <= resp_value_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   assign bus.req_ready_out   = (state_q == IDLE);
   assign bus.address_out     = address_q;
   assign bus.read_out        = read_q;
   assign bus.write_mask_out  = wmask_q;
   assign bus.write_value_out = wvalue_q;
   assign bus.resp_valid_out  = resp_valid_q;
   assign bus.resp_value_out  = resp_value_q;
   assign bus.resp_fault_out  = resp_fault_q;

endmodule

// File: tb/tb_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_bus_initiator
//   Directed testbench for bus_initiator: aligned/misaligned loads and
//   stores, sign/zero extension, wait states, timeout, address wrap and
//   reset in the middle of a split access.
// ---------------------------------------------------------------------------
module tb_bus_initiator;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   bus_initiator_if bus ();

   bus_initiator #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge; outputs are then stable for sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present a request for one edge (accepted at that edge when idle)
   task automatic issue(input logic wr, input logic [1:0] wd, input logic uns,
                        input logic [31:0] addr, input logic [31:0] val);
      bus.req_write_in    = wr;
      bus.req_width_in    = wd;
      bus.req_unsigned_in = uns;
      bus.req_address_in  = addr;
      bus.req_value_in    = val;
      bus.req_valid_in    = 1'b1;
      step();
      bus.req_valid_in    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_checks++;
      if (bus.req_ready_out !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready_out);
      end
      n_checks++;
      if (bus.read_out !== 1'b0 || bus.write_mask_out !== 4'h0) begin
         n_fail++; $display("FAIL reset_strobes: got read=%b mask=%h expected 0/0", bus.read_out, bus.write_mask_out);
      end
      n_checks++;
      if (bus.address_out !== 32'h0 || bus.write_value_out !== 32'h0) begin
         n_fail++; $display("FAIL reset_bus: got addr=%h data=%h expected 0/0", bus.address_out, bus.write_value_out);
      end
      n_checks++;
      if (bus.resp_valid_out !== 1'b0 || bus.resp_value_out !== 32'h0 || bus.resp_fault_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_resp: got v=%b val=%h f=%b expected 0", bus.resp_valid_out, bus.resp_value_out, bus.resp_fault_out);
      end
      reset = 1'b0;
      step();
      $display("reset: done");
   endtask

   task automatic test_word_load();
      bus.ready_in = 1'b1;
      bus.read_value_in = 32'hDEADBEEF;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
      n_checks++;
      if (bus.address_out !== 32'h1000 || bus.read_out !== 1'b1 || bus.write_mask_out !== 4'h0) begin
         n_fail++; $display("FAIL word_load_beat: got addr=%h rd=%b mask=%h expected 00001000/1/0", bus.address_out, bus.read_out, bus.write_mask_out);
      end
      n_checks++;
      if (bus.req_ready_out !== 1'b0) begin
         n_fail++; $display("FAIL word_load_busy: got ready=%b expected 0", bus.req_ready_out);
      end
      step();
      n_checks++;
      if (bus.resp_valid_out !== 1'b1 || bus.resp_value_out !== 32'hDEADBEEF || bus.resp_fault_out !== 1'b0) begin
         n_fail++; $display("FAIL word_load_resp: got v=%b val=%h f=%b expected 1/deadbeef/0", bus.resp_valid_out, bus.resp_value_out, bus.resp_fault_out);
      end
      n_checks++;
      if (bus.read_out !== 1'b0 || bus.req_ready_out !== 1'b0) begin
         n_fail++; $display("FAIL word_load_respbus: got rd=%b ready=%b expected 0/0", bus.read_out, bus.req_ready_out);
      end
      step();
      n_checks++;
      if (bus.resp_valid_out !== 1'b0 || bus.req_ready_out !== 1'b1) begin
         n_fail++; $display("FAIL word_load_after: got v=%b ready=%b expected 0/1", bus.resp_valid_out, bus.req_ready_out);
      end
      $display("word load 0x1000 -> %h", bus.resp_value_out);
   endtask

   task automatic test_byte_load();
      logic [31:0] exp_val [2];
      exp_val[0] = 32'hFFFF_FF80;
      exp_val[1] = 32'h0000_0080;
      bus.ready_in = 1'b1;
      bus.read_value_in = 32'h80123456;
      for (int u = 0; u < 2; u++) begin
         issue(1'b0, 2'b00, u[0], 32'h0000_1003, 32'h0);
         n_checks++;
         if (bus.address_out !== 32'h1000 || bus.read_out !== 1'b1 || bus.write_mask_out !== 4'h0) begin
            n_fail++; $display("FAIL byte_load_beat u=%0d: got addr=%h rd=%b mask=%h expected 00001000/1/0", u, bus.address_out, bus.read_out, bus.write_mask_out);
         end
         step();
         n_checks++;
         if (bus.resp_valid_out !== 1'b1 || bus.resp_value_out !== exp_val[u]) begin
            n_fail++; $display("FAIL byte_load_resp u=%0d: got v=%b val=%h expected 1/%h", u, bus.resp_valid_out, bus.resp_value_out, exp_val[u]);
         end
         $display("byte load 0x1003 unsigned=%0d -> %h", u, bus.resp_value_out);
         step();
      end
   endtask

   task automatic test_split_store();
      bus.ready_in = 1'b1;
      bus.read_value_in = 32'h0;
      issue(1'b1, 2'b10, 1'b0, 32'h0000_2002, 32'h11223344);
      n_checks++;
      if (bus.address_out !== 32'h2000 || bus.write_mask_out !== 4'b1100 || bus.write_value_out !== 32'h33440000 || bus.read_out !== 1'b0) begin
         n_fail++; $display("FAIL split_store_beat0: got addr=%h mask=%b data=%h rd=%b expected 00002000/1100/33440000/0", bus.address_out, bus.write_mask_out, bus.write_value_out, bus.read_out);
      end
      step();
      n_checks++;
      if (bus.address_out !== 32'h2004 || bus.write_mask_out !== 4'b0011 || bus.write_value_out !== 32'h00001122 || bus.resp_valid_out !== 1'b0) begin
         n_fail++; $display("FAIL split_store_beat1: got addr=%h mask=%b data=%h v=%b expected 00002004/0011/00001122/0", bus.address_out, bus.write_mask_out, bus.write_value_out, bus.resp_valid_out);
      end
      step();
      n_checks++;
      if (bus.resp_valid_out !== 1'b1 || bus.resp_value_out !== 32'h0 || bus.write_mask_out !== 4'h0) begin
         n_fail++; $display("FAIL split_store_resp: got v=%b val=%h mask=%h expected 1/0/0", bus.resp_valid_out, bus.resp_value_out, bus.write_mask_out);
      end
      $display("split store 0x2002 <- 11223344 resp=%h", bus.resp_value_out);
      step();
   endtask

   task automatic test_split_load();
      logic [31:0] exp_val [2];
      exp_val[0] = 32'hFFFF_CDAB;
      exp_val[1] = 32'h0000_CDAB;
      bus.ready_in = 1'b1;
      for (int u = 0; u < 2; u++) begin
         bus.read_value_in = 32'hAB000000;
         issue(1'b0, 2'b01, u[0], 32'h0000_3003, 32'h0);
         n_checks++;
         if (bus.address_out !== 32'h3000 || bus.read_out !== 1'b1) begin
            n_fail++; $display("FAIL split_load_beat0 u=%0d: got addr=%h rd=%b expected 00003000/1", u, bus.address_out, bus.read_out);
         end
         step();
         bus.read_value_in = 32'h000000CD;
         n_checks++;
         if (bus.address_out !== 32'h3004 || bus.read_out !== 1'b1) begin
            n_fail++; $display("FAIL split_load_beat1 u=%0d: got addr=%h rd=%b expected 00003004/1", u, bus.address_out, bus.read_out);
         end
         step();
         n_checks++;
         if (bus.resp_valid_out !== 1'b1 || bus.resp_value_out !== exp_val[u]) begin
            n_fail++; $display("FAIL split_load_resp u=%0d: got v=%b val=%h expected 1/%h", u, bus.resp_valid_out, bus.resp_value_out, exp_val[u]);
         end
         $display("halfword load 0x3003 unsigned=%0d -> %h", u, bus.resp_value_out);
         step();
      end
   endtask

   task automatic test_wait_states();
      int beat_cycles;
      bus.ready_in = 1'b0;
      issue(1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h000000A5);
      beat_cycles = 0;
      for (int i = 0; i < 10 && !bus.resp_valid_out; i++) begin
         n_checks++;
         if (bus.write_mask_out !== 4'b0010 || bus.write_value_out !== 32'h0000A500 || bus.address_out !== 32'h6000) begin
            n_fail++; $display("FAIL wait_hold cyc=%0d: got addr=%h mask=%b data=%h expected 00006000/0010/0000a500", i, bus.address_out, bus.write_mask_out, bus.write_value_out);
         end
         beat_cycles++;
         bus.ready_in = (beat_cycles == 3);
         step();
      end
      bus.ready_in = 1'b1;
      n_checks++;
      if (beat_cycles !== 3 || bus.resp_valid_out !== 1'b1 || bus.resp_fault_out !== 1'b0) begin
         n_fail++; $display("FAIL wait_latency: got beats=%0d v=%b f=%b expected 3/1/0", beat_cycles, bus.resp_valid_out, bus.resp_fault_out);
      end
      $display("byte store 0x6001 with 2 waits: beat cycles %0d", beat_cycles);
      step();
   endtask

   task automatic test_timeout();
      int high_cycles;
      bus.ready_in = 1'b0;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
      high_cycles = 0;
      for (int i = 0; i < 40 && !bus.resp_valid_out; i++) begin
         if (bus.read_out === 1'b1) high_cycles++;
         step();
      end
      n_checks++;
      if (high_cycles !== 16) begin
         n_fail++; $display("FAIL timeout_strobe_len: got %0d cycles expected 16", high_cycles);
      end
      n_checks++;
      if (bus.resp_valid_out !== 1'b1 || bus.resp_fault_out !== 1'b1 || bus.resp_value_out !== 32'h0 || bus.read_out !== 1'b0) begin
         n_fail++; $display("FAIL timeout_resp: got v=%b f=%b val=%h rd=%b expected 1/1/0/0", bus.resp_valid_out, bus.resp_fault_out, bus.resp_value_out, bus.read_out);
      end
      step();
      n_checks++;
      if (bus.req_ready_out !== 1'b1 || bus.resp_valid_out !== 1'b0) begin
         n_fail++; $display("FAIL timeout_after: got ready=%b v=%b expected 1/0", bus.req_ready_out, bus.resp_valid_out);
      end
      $display("load 0x4000 timed out after %0d strobe cycles", high_cycles);
      bus.ready_in = 1'b1;
   endtask

   task automatic test_wrap();
      bus.ready_in = 1'b1;
      issue(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000BEEF);
      n_checks++;
      if (bus.address_out !== 32'hFFFFFFFC || bus.write_mask_out !== 4'b1000 || bus.write_value_out !== 32'hEF000000) begin
         n_fail++; $display("FAIL wrap_beat0: got addr=%h mask=%b data=%h expected fffffffc/1000/ef000000", bus.address_out, bus.write_mask_out, bus.write_value_out);
      end
      step();
      n_checks++;
      if (bus.address_out !== 32'h0 || bus.write_mask_out !== 4'b0001 || bus.write_value_out !== 32'h000000BE) begin
         n_fail++; $display("FAIL wrap_beat1: got addr=%h mask=%b data=%h expected 00000000/0001/000000be", bus.address_out, bus.write_mask_out, bus.write_value_out);
      end
      step();
      n_checks++;
      if (bus.resp_valid_out !== 1'b1) begin
         n_fail++; $display("FAIL wrap_resp: got v=%b expected 1", bus.resp_valid_out);
      end
      $display("halfword store 0xffffffff wraps to 0x00000000");
      step();
   endtask

   task automatic test_reset_mid_beat();
      logic seen_resp;
      bus.ready_in = 1'b1;
      issue(1'b1, 2'b10, 1'b0, 32'h0000_2002, 32'h11223344);
      step();   // now in BEAT1
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if (bus.read_out !== 1'b0 || bus.write_mask_out !== 4'h0 || bus.address_out !== 32'h0 || bus.resp_valid_out !== 1'b0) begin
         n_fail++; $display("FAIL midreset_state: got rd=%b mask=%h addr=%h v=%b expected 0/0/0/0", bus.read_out, bus.write_mask_out, bus.address_out, bus.resp_valid_out);
      end
      n_checks++;
      if (bus.req_ready_out !== 1'b1) begin
         n_fail++; $display("FAIL midreset_ready: got %b expected 1", bus.req_ready_out);
      end
      seen_resp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.resp_valid_out === 1'b1 || bus.write_mask_out !== 4'h0) seen_resp = 1'b1;
      end
      n_checks++;
      if (seen_resp !== 1'b0) begin
         n_fail++; $display("FAIL midreset_quiet: got activity=%b expected 0", seen_resp);
      end
      bus.read_value_in = 32'h12345678;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
      step();
      n_checks++;
      if (bus.resp_valid_out !== 1'b1 || bus.resp_value_out !== 32'h12345678 || bus.resp_fault_out !== 1'b0) begin
         n_fail++; $display("FAIL midreset_recover: got v=%b val=%h f=%b expected 1/12345678/0", bus.resp_valid_out, bus.resp_value_out, bus.resp_fault_out);
      end
      $display("reset during beat1, then load 0x5000 -> %h", bus.resp_value_out);
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset               = 1'b1;
      bus.req_valid_in    = 1'b0;
      bus.req_write_in    = 1'b0;
      bus.req_width_in    = 2'b00;
      bus.req_unsigned_in = 1'b0;
      bus.req_address_in  = 32'h0;
      bus.req_value_in    = 32'h0;
      bus.read_value_in   = 32'h0;
      bus.ready_in        = 1'b0;

      test_reset();
      test_word_load();
      test_byte_load();
      test_split_store();
      test_split_load();
      test_wait_states();
      test_timeout();
      test_wrap();
      test_reset_mid_beat();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // hard stop in case a task never returns
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Load/store front end of the CPU data path; initiator side of the single-cycle peripheral/memory bus.
- The bus is used by the timer, RAM and other responders: word address, read strobe, per-byte write mask, same-cycle read data.
- Accepts one byte, halfword or word load/store from the pipeline through a valid/ready handshake.
- Converts it to one or two word-aligned bus beats, splitting misaligned accesses. Merges and extends read data, then returns one response.
- Supports responder wait states via `ready_in` and an optional per-beat timeout that reports a fault.

Parameters:
- TIMEOUT_CYCLES, 16, max consecutive strobe cycles per beat without `ready_in` before abort; 0 disables the timeout; legal range 0..65535.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid_in`  in  1  pipeline request valid.
- `req_ready_out`  out  1  block can accept a request (high only in IDLE).
- `req_write_in`  in  1  1 = store, 0 = load.
- `req_width_in`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `req_unsigned_in`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_address_in`  in  32  byte address, any alignment.
- `req_value_in`  in  32  store data, right-justified.
- `resp_valid_out`  out  1  one-cycle response pulse.
- `resp_value_out`  out  32  extended load data; 0 for stores and faults.
- `resp_fault_out`  out  1  beat timed out.
- `address_out`  out  32  bus word address, bits [1:0] always 0.
- `read_out`  out  1  bus read strobe.
- `write_mask_out`  out  4  bus byte-lane write enables.
- `write_value_out`  out  32  bus write data, lane-aligned.
- `read_value_in`  in  32  responder read data, valid in the cycle `ready_in` = 1.
- `ready_in`  in  1  responder completes the current beat this cycle.

Behaviour:
- **Reset.** On a `clk` edge with `reset` = 1:
  - state = IDLE.
  - `address_out`, `read_out`, `write_mask_out`, `write_value_out`, `resp_valid_out`, `resp_value_out`, `resp_fault_out` and the timeout counter are all cleared to 0.
  - `req_ready_out` = 1 from the first cycle after that edge.
  - Reset mid-beat abandons the access: no response is produced and no further bus strobes are driven.
- **States:** IDLE, BEAT0, BEAT1, RESP.
- **IDLE.**
  - `req_ready_out` = 1.
  - When `req_valid_in` = 1, latch the request; go to BEAT0 on the next edge.
- **Lane computation**, with off = `address[1:0]`:
  - m8 = base << off, where base = 0001 (byte), 0011 (halfword), 1111 (word).
  - d64 = {32'b0, value} << (8*off).
  - Beat0: address = {addr[31:2], 00}, mask = m8[3:0], data = d64[31:0].
  - Beat1: address = beat0 address + 4 (32-bit wrap: 0xFFFFFFFC + 4 = 0x00000000), mask = m8[7:4], data = d64[63:32].
  - Split is needed iff m8[7:4] ≠ 0.
- **Strobes.** All bus outputs are registered.
  - Load: `read_out` = 1 and `write_mask_out` = 0.
  - Store: `read_out` = 0 and `write_mask_out` = the beat mask.
  - Strobes are held constant until the beat completes.
  - `read_out` and `write_mask_out` are 0 in IDLE and RESP.
- **Beat completion** = a cycle in BEAT0/BEAT1 with `ready_in` = 1.
  - Capture `read_value_in` into that beat's data register.
  - BEAT0 then goes to BEAT1 if split, else RESP; BEAT1 then goes to RESP.
  - The timeout counter clears at each beat start.
- **Timeout.**
  - The counter increments each beat cycle with `ready_in` = 0.
  - If TIMEOUT_CYCLES ≠ 0 and the beat has had TIMEOUT_CYCLES cycles without `ready_in`, abort the beat and go to RESP with fault = 1.
  - Strobes are therefore held exactly TIMEOUT_CYCLES cycles.
  - A timeout in BEAT0 skips BEAT1.
- **RESP** lasts one cycle: `resp_valid_out` = 1, then IDLE. `req_ready_out` = 0 during RESP.
- **Load result:**
  - r64 = {beat1_data, beat0_data} >> (8*off).
  - Take r64[7:0], r64[15:0] or r64[31:0] by width.
  - Sign-extend from the top bit unless `req_unsigned_in` = 1.
  - Beat1 data is 0 if no split.
- **Store/fault response values:** stores give `resp_value_out` = 0; a fault forces `resp_value_out` = 0.
- **Latency**, with the request accepted at edge T:
  - Unsplit, zero-wait: bus cycle T+1, RESP T+2.
  - Split, zero-wait: beats T+1 and T+2, RESP T+3.
  - Each wait cycle adds 1.
- **Throughput:** a new request is accepted no earlier than the cycle after RESP.
- `ready_in` is ignored outside BEAT0/BEAT1.

Test Plan:
- Aligned word load at 0x00001000, `read_value_in` = 0xDEADBEEF, `ready_in` = 1 → T+1: `address_out` = 0x1000, `read_out` = 1; T+2: `resp_valid_out` = 1, value 0xDEADBEEF, fault 0.
- Byte load at 0x00001003, `read_value_in` = 0x80123456 → signed gives 0xFFFFFF80; unsigned gives 0x00000080. Single beat, mask 0000.
- Word store 0x11223344 to 0x00002002 → beat0: addr 0x2000, mask 1100, data 0x33440000; beat1: addr 0x2004, mask 0011, data 0x00001122; RESP at T+3 with value 0.
- Signed halfword load at 0x00003003, beat0 data 0xAB000000, beat1 data 0x000000CD → two beats (0x3000, 0x3004); response 0xFFFFCDAB; unsigned gives 0x0000CDAB.
- Load with `ready_in` held 0, TIMEOUT_CYCLES = 16 → `read_out` high exactly 16 cycles; then `resp_valid_out` = 1, `resp_fault_out` = 1, value 0; `req_ready_out` = 1 the next cycle.
- Split store with `reset` pulsed during BEAT1 → after the edge all strobes 0, no `resp_valid_out`, `req_ready_out` = 1; a following aligned load completes normally.
